// File: rtl/mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_sequencer
// Purpose  : Sequential front-end for an external 4-to-1 bit multiplexer.
//            Captures a 4-bit word onto the mux data inputs, walks the mux
//            select through all four positions and returns the selected bit
//            as a valid/ready serial stream (4-bit parallel-to-serial).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LSB_FIRST : 1 -> select order 00,01,10,11 ; 0 -> 11,10,01,00
//   GAP       : idle cycles between consecutive bits (0..15), none after last
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   serialise request, sampled only when idle
//   data_in    in   [3:0] word captured on the accepted start
//   i0..i3     out  registered hold bits to the mux data inputs
//   s0, s1     out  registered mux select (s1 = MSB)
//   mux_out    in   mux output fed back
//   ser_bit    out  serial bit (mux_out qualified by ser_valid)
//   ser_valid  out  ser_bit valid
//   ser_ready  in   consumer accepts the bit
//   busy       out  high whenever not idle
//   done       out  one-cycle pulse after the final bit transfers
// ============================================================================
module mux_sel_sequencer #(
   parameter int LSB_FIRST = 1,
   parameter int GAP       = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] data_in,
   output logic       i0,
   output logic       i1,
   output logic       i2,
   output logic       i3,
   output logic       s0,
   output logic       s1,
   input  logic       mux_out,
   output logic       ser_bit,
   output logic       ser_valid,
   input  logic       ser_ready,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_send   = 2'd1;
   localparam logic [1:0] c_st_gap    = 2'd2;

   localparam logic [1:0] c_first_sel = (LSB_FIRST != 0) ? 2'b00 : 2'b11;
   localparam logic [1:0] c_last_sel  = (LSB_FIRST != 0) ? 2'b11 : 2'b00;
   localparam logic [3:0] c_gap       = 4'(GAP);

   logic [1:0] r_state;
   logic [1:0] w_next_state;
   logic [3:0] r_hold;
   logic [1:0] r_sel;
   logic [1:0] w_sel_next;
   logic [3:0] r_gap_cnt;
   logic       r_done;
   logic       w_xfer;
   logic       w_last;
   logic       w_valid;
   logic       w_busy;

   // ser_valid is decoded from state only, so ser_ready never reaches it
   // combinationally.
   assign w_xfer = (r_state == c_st_send) && ser_ready;
   assign w_last = (r_sel == c_last_sel);

   generate
      if (LSB_FIRST != 0) begin : g_step_up
         assign w_sel_next = r_sel + 2'd1;
      end else begin : g_step_down
         assign w_sel_next = r_sel - 2'd1;
      end
   endgenerate

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: begin
            if (start) begin
               w_next_state = c_st_send;
            end
         end
         c_st_send: begin
            if (w_xfer) begin
               if (w_last) begin
                  w_next_state = c_st_idle;
               end else if (c_gap != 4'd0) begin
                  w_next_state = c_st_gap;
               end
            end
         end
         c_st_gap: begin
            // Counter is loaded with GAP, so leaving on the value 1 yields
            // exactly GAP invalid cycles.
            if (r_gap_cnt <= 4'd1) begin
               w_next_state = c_st_send;
            end
         end
         default: begin
            w_next_state = c_st_idle;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      w_valid = 1'b0;
      w_busy  = 1'b0;
      case (r_state)
         c_st_send: begin
            w_valid = 1'b1;
            w_busy  = 1'b1;
         end
         c_st_gap: begin
            w_busy  = 1'b1;
         end
         default: begin
            w_valid = 1'b0;
            w_busy  = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold    <= 4'd0;
         r_sel     <= 2'b00;
         r_gap_cnt <= 4'd0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (start) begin
                  r_hold <= data_in;
                  r_sel  <= c_first_sel;
               end
            end
            c_st_send: begin
               if (w_xfer) begin
                  if (w_last) begin
                     // Select and hold bits are left as-is until next start.
                     r_done <= 1'b1;
                  end else begin
                     r_sel     <= w_sel_next;
                     r_gap_cnt <= c_gap;
                  end
               end
            end
            c_st_gap: begin
               if (r_gap_cnt != 4'd0) begin
                  r_gap_cnt <= r_gap_cnt - 4'd1;
               end
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign i0        = r_hold[0];
   assign i1        = r_hold[1];
   assign i2        = r_hold[2];
   assign i3        = r_hold[3];
   assign s0        = r_sel[0];
   assign s1        = r_sel[1];
   assign ser_valid = w_valid;
   assign ser_bit   = mux_out & w_valid;
   assign busy      = w_busy;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mux_sel_sequencer
// Purpose  : Self-checking bench for mux_sel_sequencer. Two instances:
//            index 0 = LSB_FIRST 1 / GAP 0, index 1 = LSB_FIRST 0 / GAP 2,
//            each with a behavioural 4-to-1 mux closing the loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sel_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [1:0] start;
   logic [1:0] ser_ready;
   logic [3:0] data_in [2];
   wire  [1:0] i0, i1, i2, i3, s0, s1, mux_out, ser_bit, ser_valid, busy, done;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   generate
      for (genvar d = 0; d < 2; d++) begin : g_dut
         wire [3:0] w_hold = {i3[d], i2[d], i1[d], i0[d]};
         assign mux_out[d] = w_hold[{s1[d], s0[d]}];

         mux_sel_sequencer #(
            .LSB_FIRST ((d == 0) ? 1 : 0),
            .GAP       ((d == 0) ? 0 : 2)
         ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[d]),
            .data_in   (data_in[d]),
            .i0        (i0[d]),
            .i1        (i1[d]),
            .i2        (i2[d]),
            .i3        (i3[d]),
            .s0        (s0[d]),
            .s1        (s1[d]),
            .mux_out   (mux_out[d]),
            .ser_bit   (ser_bit[d]),
            .ser_valid (ser_valid[d]),
            .ser_ready (ser_ready[d]),
            .busy      (busy[d]),
            .done      (done[d])
         );
      end
   endgenerate

   // ------------------------------------------------------------------ model
   // Word-level view: which bit (k = 0..3 in send order) is pending, how many
   // idle cycles remain before it, and whether a word is in flight.
   logic [3:0] m_word   [2] = '{4'd0, 4'd0};
   logic [1:0] m_sel    [2] = '{2'd0, 2'd0};
   int         m_k      [2] = '{0, 0};
   int         m_gap    [2] = '{0, 0};
   bit         m_active [2] = '{1'b0, 1'b0};
   bit         m_done   [2] = '{1'b0, 1'b0};

   function automatic int gap_of(int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic logic [1:0] pos_of(int d, int k);
      return (d == 0) ? 2'(k) : 2'(3 - k);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            m_word[d]   <= 4'd0;
            m_sel[d]    <= 2'd0;
            m_k[d]      <= 0;
            m_gap[d]    <= 0;
            m_active[d] <= 1'b0;
            m_done[d]   <= 1'b0;
         end else begin
            m_done[d] <= 1'b0;
            if (!m_active[d]) begin
               if (start[d]) begin
                  m_word[d]   <= data_in[d];
                  m_k[d]      <= 0;
                  m_sel[d]    <= pos_of(d, 0);
                  m_gap[d]    <= 0;
                  m_active[d] <= 1'b1;
               end
            end else if (m_gap[d] > 0) begin
               m_gap[d] <= m_gap[d] - 1;
            end else if (ser_ready[d]) begin
               if (m_k[d] == 3) begin
                  m_active[d] <= 1'b0;
                  m_done[d]   <= 1'b1;
               end else begin
                  m_k[d]   <= m_k[d] + 1;
                  m_sel[d] <= pos_of(d, m_k[d] + 1);
                  m_gap[d] <= gap_of(d);
               end
            end
         end
      end
   end

   function automatic logic [9:0] exp_out(int d);
      logic       v;
      logic       b;
      logic [3:0] w;
      v = m_active[d] && (m_gap[d] == 0);
      w = m_word[d];
      b = v ? w[m_sel[d]] : 1'b0;
      return {w, m_sel[d], b, v, m_active[d], m_done[d]};
   endfunction

   function automatic logic [9:0] act_out(int d);
      return {i3[d], i2[d], i1[d], i0[d], s1[d], s0[d],
              ser_bit[d], ser_valid[d], busy[d], done[d]};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("cycle_out[%0d]", d), 32'(act_out(d)), 32'(exp_out(d)));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------ stimulus
   initial begin : stim
      logic [3:0] t1_bits;
      logic [3:0] t3_bits;
      logic [3:0] t4_bits;
      int nbits, gap_run, done_cyc, last_cyc;
      bit seen_done;

      rst_n      = 1'b0;
      start      = 2'b00;
      ser_ready  = 2'b11;
      data_in[0] = 4'd0;
      data_in[1] = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      check("reset_outs0", 32'(act_out(0)), 0);
      check("reset_outs1", 32'(act_out(1)), 0);
      tick();

      // ---- basic order: 0101, LSB first, no gap
      t1_bits    = 4'b0101;
      data_in[0] = 4'b0101;
      start[0]   = 1'b1;
      tick();
      start[0]   = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("t1_sel",   32'({s1[0], s0[0]}), c);
         check("t1_bit",   32'(ser_bit[0]), 32'(t1_bits[c]));
         check("t1_valid", 32'(ser_valid[0]), 1);
         check("t1_busy",  32'(busy[0]), 1);
         check("t1_done_low", 32'(done[0]), 0);
         tick();
      end
      check("t1_done",     32'(done[0]), 1);
      check("t1_busy_end", 32'(busy[0]), 0);
      tick();
      check("t1_done_pulse", 32'(done[0]), 0);
      tick();

      // ---- backpressure: ready low in cycles 2-3
      data_in[0] = 4'b0101;
      start[0]   = 1'b1;
      tick();                                   // cycle 1
      start[0]   = 1'b0;
      check("t2_sel_c1", 32'({s1[0], s0[0]}), 0);
      check("t2_bit_c1", 32'(ser_bit[0]), 1);
      tick();                                   // cycle 2
      ser_ready[0] = 1'b0;
      for (int c = 0; c < 2; c++) begin
         check("t2_stall_sel",   32'({s1[0], s0[0]}), 1);
         check("t2_stall_bit",   32'(ser_bit[0]), 0);
         check("t2_stall_valid", 32'(ser_valid[0]), 1);
         tick();                                // cycles 3, 4
      end
      ser_ready[0] = 1'b1;
      check("t2_sel_c4", 32'({s1[0], s0[0]}), 1);
      tick();
      check("t2_sel_c5", 32'({s1[0], s0[0]}), 2);
      check("t2_bit_c5", 32'(ser_bit[0]), 1);
      tick();
      check("t2_sel_c6", 32'({s1[0], s0[0]}), 3);
      check("t2_bit_c6", 32'(ser_bit[0]), 0);
      tick();
      check("t2_done_c7", 32'(done[0]), 1);
      tick();

      // ---- gap and order: GAP 2, MSB first, 1100
      t3_bits    = 4'b0011;                     // stream order: 1,1,0,0
      data_in[1] = 4'b1100;
      start[1]   = 1'b1;
      tick();
      start[1]   = 1'b0;
      nbits = 0; gap_run = 0; done_cyc = 0; last_cyc = 0; seen_done = 1'b0;
      for (int c = 1; c <= 40 && !seen_done; c++) begin
         if (ser_valid[1]) begin
            if (nbits > 0) check("t3_gap_len", gap_run, 2);
            if (nbits < 4) begin
               check("t3_sel", 32'({s1[1], s0[1]}), 3 - nbits);
               check("t3_bit", 32'(ser_bit[1]), 32'(t3_bits[nbits]));
            end
            nbits++;
            gap_run  = 0;
            last_cyc = c;
         end else if (done[1]) begin
            seen_done = 1'b1;
            done_cyc  = c;
         end else begin
            gap_run++;
         end
         tick();
      end
      check("t3_nbits",    nbits, 4);
      check("t3_last_bit", last_cyc, 10);
      check("t3_done_cyc", done_cyc, 11);
      tick();

      // ---- start handling: ignored while busy, accepted in the done cycle
      t4_bits    = 4'b0011;
      data_in[0] = 4'b0101;
      start[0]   = 1'b1;
      tick();                                   // cycle 1
      start[0]   = 1'b0;
      tick();                                   // cycle 2
      data_in[0] = 4'b1010;
      start[0]   = 1'b1;
      tick();                                   // cycle 3
      start[0]   = 1'b0;
      check("t4_hold_kept", 32'({i3[0], i2[0], i1[0], i0[0]}), 32'h5);
      check("t4_sel_c3",    32'({s1[0], s0[0]}), 2);
      check("t4_bit_c3",    32'(ser_bit[0]), 1);
      tick();                                   // cycle 4
      check("t4_bit_c4",    32'(ser_bit[0]), 0);
      tick();                                   // cycle 5
      check("t4_done_c5",   32'(done[0]), 1);
      data_in[0] = 4'b0011;
      start[0]   = 1'b1;
      tick();                                   // cycle 6
      start[0]   = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("t4_w2_hold", 32'({i3[0], i2[0], i1[0], i0[0]}), 32'h3);
         check("t4_w2_sel",  32'({s1[0], s0[0]}), c);
         check("t4_w2_bit",  32'(ser_bit[0]), 32'(t4_bits[c]));
         tick();
      end
      check("t4_w2_done", 32'(done[0]), 1);
      tick();

      // ---- asynchronous reset after the second bit transfers
      data_in[0] = 4'b0101;
      start[0]   = 1'b1;
      tick();                                   // cycle 1
      start[0]   = 1'b0;
      tick();                                   // cycle 2
      tick();                                   // cycle 3: two bits sent
      check("t5_pre_sel", 32'({s1[0], s0[0]}), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_zero0", 32'(act_out(0)), 0);
      check("t5_async_zero1", 32'(act_out(1)), 0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         check("t5_no_done", 32'(done[0]), 0);
         check("t5_idle",    32'(busy[0]), 0);
         tick();
      end
      data_in[0] = 4'b1111;
      start[0]   = 1'b1;
      tick();
      start[0]   = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("t5_ones_bit",   32'(ser_bit[0]), 1);
         check("t5_ones_valid", 32'(ser_valid[0]), 1);
         tick();
      end
      check("t5_done", 32'(done[0]), 1);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Sequential front-end for the 4-to-1 bit multiplexer.
- Latches a 4-bit word onto the mux data inputs (i0..i3) and steps the select lines (s1:s0) through all four positions.
- Returns the selected bit (mux out) to a downstream consumer as a serial stream using a valid/ready handshake.
- Together with the mux, forms a 4-bit parallel-to-serial converter.

Parameters:
- LSB_FIRST, 1, 1: select order 00,01,10,11; 0: order 11,10,01,00.
- GAP, 0, number of idle cycles (ser_valid low) between consecutive bits; range 0..15; no gap after the last bit.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to serialise data_in; sampled only in IDLE.
- data_in  input  4  word to serialise; captured on the accepted start.
- i0, i1, i2, i3  output  1 each  registered hold bits driven to the mux data inputs (i0 = data_in[0]).
- s0, s1  output  1 each  registered mux select (s1 = MSB).
- mux_out  input  1  mux output, fed back.
- ser_bit  output  1  current serial bit; combinational pass-through of mux_out, qualified by ser_valid.
- ser_valid  output  1  ser_bit valid.
- ser_ready  input  1  consumer accepts the bit.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final bit transfers.

Behaviour:
- Reset (asynchronous, any state, including mid-word):
  - i0..i3 = 0, s1:s0 = 00, ser_valid = 0, busy = 0, done = 0, state = IDLE, gap counter = 0.
  - The in-flight word is discarded; no done pulse is generated.
- States: IDLE, SEND, GAP_WAIT.
- IDLE:
  - done is low except for the pulse cycle.
  - start = 1 at a clock edge captures data_in into i0..i3, loads the select with the first index (00 if LSB_FIRST, else 11), and moves to SEND.
  - start is accepted in the same cycle that done is high.
- SEND:
  - ser_valid = 1; ser_bit = mux_out.
  - Select and hold bits stay constant while ser_ready = 0. ser_valid never drops without a transfer.
  - A transfer is ser_valid & ser_ready at a clock edge.
- Transfer of a non-final bit:
  - The select advances one position: +1 if LSB_FIRST, else -1. It never wraps, because the final bit ends the word.
  - GAP = 0: stay in SEND, so the next bit is valid the very next cycle.
  - GAP > 0: go to GAP_WAIT with the counter loaded to GAP.
- GAP_WAIT:
  - ser_valid = 0; the counter decrements each cycle.
  - Return to SEND in the cycle after the counter reaches 1, giving exactly GAP invalid cycles.
- Transfer of the final bit (select 11 if LSB_FIRST, else 00):
  - Next state is IDLE; done = 1 for exactly that one cycle; busy = 0 from that cycle.
  - Select and hold bits retain their last values until the next start.
- start while busy: ignored, with no effect on the hold bits or the select.
- data_in changes after capture: no effect.
- Latency with GAP = 0 and ser_ready held high:
  - Start accepted at edge 0.
  - Bits valid in cycles 1, 2, 3, 4.
  - done in cycle 5.
  - Total = 4 + 3·GAP cycles from start to the last bit.
- Fully synchronous to clk apart from the reset. No combinational path from ser_ready to ser_valid.

Test Plan:
- Basic order:
  - Stimulus: LSB_FIRST = 1, GAP = 0, data_in = 0101, start pulse, ser_ready = 1, real mux instance attached.
  - Required: s1:s0 = 00, 01, 10, 11 in cycles 1–4; ser_bit = 1, 0, 1, 0; done high in cycle 5 only; busy high in cycles 1–4.
- Backpressure:
  - Stimulus: same word, ser_ready low in cycles 2–3.
  - Required: select holds at 01 and ser_bit holds at 0 with ser_valid = 1 through the stall; the stream is still 1, 0, 1, 0; done arrives 2 cycles later (cycle 7).
- Gap and order:
  - Stimulus: GAP = 2, LSB_FIRST = 0, data_in = 1100.
  - Required: select sequence 11, 10, 01, 00; bits 1, 1, 0, 0; exactly 2 ser_valid-low cycles between bits; no gap before done.
- Start handling:
  - Stimulus: start with data_in = 1010 asserted while busy, then start asserted in the done cycle with data_in = 0011.
  - Required: the first start is ignored (stream unchanged); the second word starts the following cycle and sends 1, 1, 0, 0 (LSB first).
- Reset mid-operation:
  - Stimulus: rst_n low asynchronously after the second bit transfers.
  - Required: all outputs 0 immediately, without waiting for a clock edge; no done pulse; after release, a new start of 1111 sends four 1s normally.
